// File: rtl/im2col_pkg.sv
// Shared types and helpers for the im2col convolution-window feeder.
package im2col_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Width of a credit counter that must hold 0..depth inclusive.
    function automatic int unsigned occ_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic cfg_error(input int unsigned ksize,
                                       input int unsigned stride,
                                       input int unsigned img_h,
                                       input int unsigned img_w,
                                       input int unsigned n_ch);
        return (ksize == 0) || (stride == 0) || (ksize > img_h) ||
               (ksize > img_w) || (ksize * ksize > n_ch);
    endfunction

endpackage

// File: rtl/im2col_chan_agen.sv
// Per-tap address generator: walks the output grid in row-major order using
// only incremental adds; the tap offset multiply happens once at load time.
module im2col_chan_agen
    import im2col_pkg::*;
#(
    parameter int CH     = 0,
    parameter int ADDR_W = 20,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  ksize,
    input  logic [DIM_W-1:0]  stride,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [ADDR_W-1:0] row_step,
    output logic [ADDR_W-1:0] addr,
    output logic              finished,
    output logic              last
);

    localparam int PW = DIM_W + 2;

    logic [PW-1:0]     row_pix, col_pix, row_next, col_next;
    logic [ADDR_W-1:0] row_base, offset;
    logic [31:0]       ksz, kr, kc;
    logic              active, col_wrap, row_end;

    // Window top-left corner in pixels; a position is the last in its row or
    // column when one more stride would push the window past the image edge.
    assign col_next = col_pix + PW'(stride);
    assign row_next = row_pix + PW'(stride);
    assign col_wrap = (col_next + PW'(ksize)) > PW'(img_w);
    assign row_end  = (row_next + PW'(ksize)) > PW'(img_h);
    assign last     = col_wrap && row_end;

    always_comb begin
        ksz    = (ksize == '0) ? 32'd1 : 32'(ksize);
        kr     = 32'(CH) / ksz;
        kc     = 32'(CH) % ksz;
        active = 32'(CH) < (ksz * ksz);
        offset = ADDR_W'(kr) * ADDR_W'(img_w) + ADDR_W'(kc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_pix  <= '0;
            col_pix  <= '0;
            row_base <= '0;
            addr     <= '0;
            finished <= 1'b1;
        end else if (init) begin
            row_pix  <= '0;
            col_pix  <= '0;
            row_base <= base_addr + offset;
            addr     <= base_addr + offset;
            finished <= !active;
        end else if (advance) begin
            if (last) begin
                finished <= 1'b1;
            end else if (col_wrap) begin
                col_pix  <= '0;
                row_pix  <= row_next;
                row_base <= row_base + row_step;
                addr     <= row_base + row_step;
            end else begin
                col_pix <= col_next;
                addr    <= addr + ADDR_W'(stride);
            end
        end
    end

endmodule

// File: rtl/im2col_fifo_feeder.sv
// Convolution-window feeder: streams each kernel tap's pixels from the image
// ROM into that tap's FIFO, arbitrated round-robin under per-FIFO credits.
module im2col_fifo_feeder
    import im2col_pkg::*;
#(
    parameter int N_CH       = 9,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 20,
    parameter int DIM_W      = 8,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  ksize,
    input  logic [DIM_W-1:0]  stride,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [N_CH-1:0]   fifo_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [N_CH-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int OCC_W = occ_bits(FIFO_DEPTH);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cfg_base, row_step;
    logic [DIM_W-1:0]  cfg_ksize, cfg_stride, cfg_img_h, cfg_img_w;
    logic              err_q, cfg_bad, start_ok, load_cfg;
    logic [N_CH-1:0]   elig, grant, finished, last_vec;
    logic [CH_W-1:0]   last_grant, grant_idx;
    logic              issue, all_fin_next, pipe_pending;
    logic [ADDR_W-1:0] chan_addr [N_CH];
    logic [N_CH-1:0]   pipe [ROM_LAT];
    int                idx;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign load_cfg = (state == S_CHECK);
    assign cfg_bad  = cfg_error(32'(cfg_ksize), 32'(cfg_stride), 32'(cfg_img_h),
                                32'(cfg_img_w), 32'(N_CH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_base   <= '0;
            cfg_ksize  <= '0;
            cfg_stride <= '0;
            cfg_img_h  <= '0;
            cfg_img_w  <= '0;
        end else if (start_ok) begin
            cfg_base   <= base_addr;
            cfg_ksize  <= ksize;
            cfg_stride <= stride;
            cfg_img_h  <= img_h;
            cfg_img_w  <= img_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            row_step <= '0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (state == S_CHECK) begin
            err_q    <= cfg_bad;
            row_step <= ADDR_W'(cfg_stride) * ADDR_W'(cfg_img_w);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CHECK;
            S_CHECK: state_next = cfg_bad ? S_DONE : S_RUN;
            S_RUN:   if (all_fin_next) state_next = S_DRAIN;
            S_DRAIN: if (!pipe_pending) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_CHECK;
            default: state_next = S_IDLE;
        endcase
    end

    // Search starts one past the previous winner so every eligible tap is
    // served within N_CH issues.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        issue     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_grant) + i) % N_CH;
            if (!issue && elig[CH_W'(idx)]) begin
                issue     = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        if (issue) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        last_grant <= CH_W'(N_CH - 1);
        else if (load_cfg) last_grant <= CH_W'(N_CH - 1);
        else if (issue)    last_grant <= grant_idx;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        logic [OCC_W-1:0] occ;
        logic             pop;

        im2col_chan_agen #(
            .CH     (c),
            .ADDR_W (ADDR_W),
            .DIM_W  (DIM_W)
        ) u_agen (
            .clk       (clk),
            .reset     (reset),
            .init      (load_cfg),
            .advance   (grant[c]),
            .base_addr (cfg_base),
            .ksize     (cfg_ksize),
            .stride    (cfg_stride),
            .img_h     (cfg_img_h),
            .img_w     (cfg_img_w),
            .row_step  (row_step),
            .addr      (chan_addr[c]),
            .finished  (finished[c]),
            .last      (last_vec[c])
        );

        // Credits are taken at issue time so reads still in the ROM pipe count
        // against FIFO space.
        assign pop     = fifo_rd[c] && (occ != '0);
        assign elig[c] = (state == S_RUN) && !finished[c] && (occ < OCC_W'(FIFO_DEPTH));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                occ <= '0;
            else if (grant[c] && !pop) occ <= occ + 1'b1;
            else if (!grant[c] && pop) occ <= occ - 1'b1;
        end
    end

    assign all_fin_next = &(finished | (grant & last_vec));
    assign rom_addr     = issue ? chan_addr[grant_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ROM_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= grant;
            for (int k = 1; k < ROM_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Tags still travelling toward the output stage after this cycle.
    always_comb begin
        pipe_pending = 1'b0;
        for (int k = 0; k < ROM_LAT - 1; k++) pipe_pending = pipe_pending | (|pipe[k]);
    end

    assign wr_en   = pipe[ROM_LAT-1];
    assign wr_data = (|wr_en) ? rom_data : '0;
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_im2col_fifo_feeder.sv
// Scoreboard bench for im2col_fifo_feeder: a window-walk reference model fills
// per-tap expectation queues; a monitor checks every FIFO write against them.
module tb_im2col_fifo_feeder;

    localparam int N_CH       = 9;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 20;
    localparam int DIM_W      = 8;
    localparam int ROM_LAT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int QD         = 512;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [DIM_W-1:0]  ksize = '0, stride = '0, img_h = '0, img_w = '0;
    logic [N_CH-1:0]   fifo_rd = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [N_CH-1:0]   wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_mem [N_CH][QD];
    int                head [N_CH];
    int                tail [N_CH];
    int                wr_count [N_CH];
    int                fifo_cnt [N_CH];
    int                wr_total, exp_total, pop_mode, mon_ch;
    logic [ADDR_W-1:0] mon_addr;
    logic [N_CH-1:0]   force_pop = '0;
    logic [N_CH-1:0]   pop_want;
    logic              prev_wr, prev_done;
    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];

    im2col_fifo_feeder #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
        .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .ksize(ksize), .stride(stride), .img_h(img_h), .img_w(img_w),
        .fifo_rd(fifo_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ 8'hA5;
    endfunction

    // ROM with ROM_LAT cycles of read latency.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_fn(rom_pipe[ROM_LAT-1]);

    task automatic check_output(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int fifo_sum();
        int s = 0;
        for (int c = 0; c < N_CH; c++) s += fifo_cnt[c];
        return s;
    endfunction

    function automatic int pending_sum();
        int s = 0;
        for (int c = 0; c < N_CH; c++) s += tail[c] - head[c];
        return s;
    endfunction

    task automatic clear_scoreboard();
        for (int c = 0; c < N_CH; c++) begin
            head[c] = 0;
            tail[c] = 0;
            wr_count[c] = 0;
        end
        wr_total  = 0;
        exp_total = 0;
    endtask

    // Reference: every tap visits every output position in row-major order.
    task automatic push_expected(input logic [ADDR_W-1:0] b, input int k, input int s,
                                 input int h, input int w);
        int oh, ow;
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        for (int c = 0; c < k * k; c++)
            for (int orow = 0; orow < oh; orow++)
                for (int ocol = 0; ocol < ow; ocol++) begin
                    exp_mem[c][tail[c]] = ADDR_W'(int'(b) + (orow * s + c / k) * w + ocol * s + c % k);
                    tail[c]++;
                    exp_total++;
                end
    endtask

    // Consumer: pops only FIFOs that really hold data, then books this cycle's write.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) fifo_cnt[c] = 0;
            fifo_rd = '0;
        end else begin
            case (pop_mode)
                0:       pop_want = '0;
                1:       pop_want = '1;
                default: pop_want = N_CH'($urandom);
            endcase
            pop_want  = pop_want | force_pop;
            force_pop = '0;
            for (int c = 0; c < N_CH; c++) begin
                fifo_rd[c] = pop_want[c] && (fifo_cnt[c] > 0);
                if (fifo_rd[c]) fifo_cnt[c]--;
                if (wr_en[c]) begin
                    fifo_cnt[c]++;
                    check_output("fifo_overflow", fifo_cnt[c] > FIFO_DEPTH, 0);
                end
            end
        end
    end

    // Monitor: pops the expectation for whichever tap is being written.
    always @(negedge clk) begin
        if (!reset) begin
            prev_wr   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (wr_en != '0) begin
                check_output("wr_en_onehot", $countones(wr_en), 1);
                if ($countones(wr_en) == 1) begin
                    mon_ch = 0;
                    for (int c = 0; c < N_CH; c++) if (wr_en[c]) mon_ch = c;
                    check_output("write_expected", tail[mon_ch] > head[mon_ch], 1);
                    if (tail[mon_ch] > head[mon_ch]) begin
                        mon_addr = exp_mem[mon_ch][head[mon_ch]];
                        head[mon_ch]++;
                        check_output("rd_addr", rom_pipe[ROM_LAT-1], mon_addr);
                        check_output("wr_data", wr_data, rom_fn(mon_addr));
                    end
                    wr_count[mon_ch]++;
                    wr_total++;
                end
            end
            if (done && !prev_done && !err) check_output("done_after_last_wr", prev_wr, 1);
            prev_wr   = (wr_en != '0);
            prev_done = done;
        end
    end

    task automatic check_reset_outputs();
        check_output("rst_rom_addr", rom_addr, 0);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_wr_data", wr_data, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
    endtask

    task automatic apply_stimulus(input logic [ADDR_W-1:0] b, input int k, input int s,
                                  input int h, input int w, input int mode, input int exp_err);
        int guard = 0;
        pop_mode = 1;
        while (fifo_sum() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_output("fifo_drained", fifo_sum(), 0);
        clear_scoreboard();
        if (exp_err == 0) push_expected(b, k, s, h, w);
        @(negedge clk);
        base_addr = b;
        ksize     = DIM_W'(k);
        stride    = DIM_W'(s);
        img_h     = DIM_W'(h);
        img_w     = DIM_W'(w);
        start     = 1'b1;
        pop_mode  = mode;
        @(negedge clk);
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        ksize     = DIM_W'($urandom);
        stride    = DIM_W'($urandom);
        img_h     = DIM_W'($urandom);
        img_w     = DIM_W'($urandom);
        check_output("check_cycle_done", done, 0);
        check_output("check_cycle_busy", busy, 0);
        @(negedge clk);
        if (exp_err != 0) begin
            check_output("err_job_done", done, 1);
            check_output("err_job_err", err, 1);
            check_output("err_job_busy", busy, 0);
        end else begin
            check_output("run_busy", busy, 1);
            check_output("run_err", err, 0);
            for (int i = 1; i <= ROM_LAT; i++) begin
                @(negedge clk);
                check_output("first_wr_latency", wr_en != '0, i == ROM_LAT);
            end
        end
    endtask

    task automatic finish_job(input int exp_err);
        int guard = 0;
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_output("done_seen", done, 1);
        @(negedge clk);
        check_output("err_flag", err, exp_err);
        check_output("busy_after_done", busy, 0);
        check_output("total_writes", wr_total, exp_total);
        check_output("words_pending", pending_sum(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k, s, h, w;
        pop_mode = 1;
        clear_scoreboard();
        #2;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        apply_stimulus(20'd0, 3, 1, 5, 5, 1, 0);
        finish_job(0);
        apply_stimulus(20'd100, 3, 2, 7, 7, 1, 0);
        finish_job(0);
        apply_stimulus(20'd5, 1, 3, 10, 7, 2, 0);
        finish_job(0);

        apply_stimulus(20'd0, 4, 1, 8, 8, 1, 1);
        repeat (5) @(negedge clk);
        check_output("err_job_no_writes", wr_total, 0);
        finish_job(1);
        apply_stimulus(20'd0, 2, 0, 6, 6, 1, 1);
        finish_job(1);

        // Credit stall: with no pops each tap stops at FIFO_DEPTH words.
        apply_stimulus(20'd0, 3, 1, 5, 5, 0, 0);
        repeat (100) @(negedge clk);
        for (int c = 0; c < N_CH; c++) check_output($sformatf("stall_count_ch%0d", c), wr_count[c], FIFO_DEPTH);
        check_output("stall_busy", busy, 1);
        start     = 1'b1;
        base_addr = 20'h3FF;
        ksize     = 8'd2;
        @(negedge clk);
        start = 1'b0;
        force_pop[3] = 1'b1;
        repeat (30) @(negedge clk);
        check_output("stall_pop_ch3", wr_count[3], FIFO_DEPTH + 1);
        check_output("stall_other_ch4", wr_count[4], FIFO_DEPTH);
        check_output("stall_total", wr_total, N_CH * FIFO_DEPTH + 1);
        pop_mode = 1;
        finish_job(0);

        // Reset in the middle of a job discards everything in flight.
        apply_stimulus(20'h200, 3, 1, 12, 12, 1, 0);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        clear_scoreboard();
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(20'hFFFF0, 2, 1, 6, 9, 2, 0);
        finish_job(0);

        for (int j = 0; j < 8; j++) begin
            k = $urandom_range(1, 3);
            s = $urandom_range(1, 3);
            h = $urandom_range(k, 12);
            w = $urandom_range(k, 12);
            apply_stimulus(ADDR_W'($urandom), k, s, h, w, $urandom_range(1, 2), 0);
            finish_job(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
